// File: rtl/adc_capture_pkg.sv
// Shared encodings for the ADC capture controller: FSM states, acquisition
// modes and the 16-bit FIFO word layout {channel tag, zero pad, code}.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_CONT = 2'd0,
        MODE_TRIG = 2'd1,
        MODE_IMM  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    localparam int WORD_W  = 16;
    localparam int TAG_W   = 4;
    localparam int TAG_LSB = 12;

    // The reserved mode behaves exactly like continuous capture.
    function automatic mode_t normMode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_CONT : mode_t'(m);
    endfunction

endpackage

// File: rtl/adc_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and a
// synchronous flush; the head reads as zero while empty.
module adc_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_rd;
    logic             w_do_wr;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
    assign w_do_rd = i_rd_en && !o_empty && !i_clear;
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd) && !i_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC sample-set capture controller: arms on a level crossing or immediately,
// serialises each set one channel per cycle into a tagged-word FIFO.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int PRECISION = 10,
    parameter int NCH       = 4,
    parameter int DEPTH     = 1024,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     adc_valid,
    input  logic [NCH*PRECISION-1:0] adc_code,
    input  logic [1:0]               mode,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [3:0]               trig_ch,
    input  logic [PRECISION-1:0]     trig_level,
    input  logic [CNT_W-1:0]         sample_count,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_rd,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [1:0]               state_o,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     done,
    input  logic                     clear_status
);

    localparam logic [3:0] LAST_CH = 4'(NCH-1);

    logic                     r_rst_sync;
    state_t                   r_state;
    state_t                   w_state_next;
    mode_t                    r_mode;
    logic [CNT_W-1:0]         r_set_cnt;
    logic [CNT_W-1:0]         w_target;
    logic [NCH*PRECISION-1:0] r_set;
    logic                     r_busy;
    logic [3:0]               r_idx;
    logic [PRECISION-1:0]     r_prev_code;
    logic                     r_prev_valid;
    logic [PRECISION-1:0]     w_trig_code;
    logic [PRECISION-1:0]     w_ser_code;
    logic [WORD_W-1:0]        w_word;
    logic                     r_overflow;
    logic                     r_underflow;
    logic                     r_done;
    logic                     w_trig;
    logic                     w_quota_met;
    logic                     w_want;
    logic                     w_accept;
    logic                     w_drop;
    logic                     w_arm_ok;
    logic                     w_enter_done;
    logic                     w_fifo_wr;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_wr_overflow;

    // Assert asynchronously, release on the next clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rst_sync <= 1'b1;
        else     r_rst_sync <= 1'b0;
    end

    always_comb begin
        w_trig_code = '0;
        w_ser_code  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (trig_ch == 4'(k)) w_trig_code = adc_code[k*PRECISION +: PRECISION];
            if (r_idx == 4'(k))   w_ser_code  = r_set[k*PRECISION +: PRECISION];
        end
        w_word = '0;
        w_word[TAG_LSB +: TAG_W]  = r_idx;
        w_word[PRECISION-1:0]     = w_ser_code;
    end

    assign w_target    = (sample_count == '0) ? CNT_W'(1) : sample_count;
    assign w_trig      = adc_valid && r_prev_valid && (r_prev_code < trig_level)
                         && (w_trig_code >= trig_level);
    assign w_quota_met = (r_mode != MODE_CONT) && (r_set_cnt >= w_target);

    always_comb begin
        w_state_next = r_state;
        w_want       = 1'b0;
        w_arm_ok     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    w_arm_ok     = 1'b1;
                    w_state_next = (mode == MODE_TRIG) ? ST_ARMED : ST_CAPTURE;
                end
            end
            ST_ARMED: begin
                if (w_trig) begin
                    w_want       = 1'b1;
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (adc_valid && !w_quota_met) w_want = 1'b1;
                if (w_quota_met && !r_busy)    w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (abort) begin
            w_state_next = ST_IDLE;
            w_want       = 1'b0;
            w_arm_ok     = 1'b0;
        end
    end

    assign w_accept      = w_want && !r_busy;
    assign w_drop        = w_want && r_busy;
    assign w_enter_done  = (r_state == ST_CAPTURE) && (w_state_next == ST_DONE);
    assign w_fifo_wr     = r_busy && !abort;
    assign w_wr_overflow = w_fifo_wr && w_fifo_full && !out_rd;

    always_ff @(posedge clk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_state      <= ST_IDLE;
            r_mode       <= MODE_CONT;
            r_set_cnt    <= '0;
            r_prev_code  <= '0;
            r_prev_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_arm_ok) r_mode <= normMode(mode);
            if (abort || w_arm_ok) r_set_cnt <= '0;
            else if (w_accept)     r_set_cnt <= r_set_cnt + CNT_W'(1);
            if (adc_valid) r_prev_code <= w_trig_code;
            if (w_arm_ok)       r_prev_valid <= 1'b0;
            else if (adc_valid) r_prev_valid <= 1'b1;
        end
    end

    // Serialiser: one channel word per cycle, channel 0 first.
    always_ff @(posedge clk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_set  <= '0;
            r_busy <= 1'b0;
            r_idx  <= '0;
        end else if (abort) begin
            r_busy <= 1'b0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_set  <= adc_code;
            r_busy <= 1'b1;
            r_idx  <= '0;
        end else if (r_busy) begin
            if (r_idx == LAST_CH) begin
                r_busy <= 1'b0;
                r_idx  <= '0;
            end else begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    // Sticky flags: a setting event beats a simultaneous clear.
    always_ff @(posedge clk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_overflow  <= w_drop || w_wr_overflow || (r_overflow && !clear_status);
            r_underflow <= (out_rd && w_fifo_empty) || (r_underflow && !clear_status);
            r_done      <= w_enter_done || (r_done && !clear_status);
        end
    end

    adc_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (r_rst_sync),
        .i_clear   (abort),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (w_word),
        .i_rd_en   (out_rd),
        .o_rd_data (out_data),
        .o_empty   (w_fifo_empty),
        .o_full    (w_fifo_full),
        .o_count   (fifo_count)
    );

    assign out_valid = !w_fifo_empty;
    assign state_o   = r_state;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign done      = r_done;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomised self-checking bench for adc_capture_ctrl; expected FIFO words and
// states come from a set-level reference model (word = tag*4096 + code).
module tb_adc_capture_ctrl;

    localparam int PRECISION = 10;
    localparam int NCH       = 4;
    localparam int DEPTH     = 16;
    localparam int CNT_W     = 16;
    localparam int SW        = NCH*PRECISION;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   adc_valid;
    logic [SW-1:0]          adc_code;
    logic [1:0]             mode;
    logic                   arm;
    logic                   abort;
    logic [3:0]             trig_ch;
    logic [PRECISION-1:0]   trig_level;
    logic [CNT_W-1:0]       sample_count;
    logic [15:0]            out_data;
    logic                   out_valid;
    logic                   out_rd;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [1:0]             state_o;
    logic                   overflow;
    logic                   underflow;
    logic                   done;
    logic                   clear_status;

    int checks = 0;
    int errors = 0;
    logic [15:0] expQ[$];

    adc_capture_ctrl #(
        .PRECISION (PRECISION),
        .NCH       (NCH),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_valid    (adc_valid),
        .adc_code     (adc_code),
        .mode         (mode),
        .arm          (arm),
        .abort        (abort),
        .trig_ch      (trig_ch),
        .trig_level   (trig_level),
        .sample_count (sample_count),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_rd       (out_rd),
        .fifo_count   (fifo_count),
        .state_o      (state_o),
        .overflow     (overflow),
        .underflow    (underflow),
        .done         (done),
        .clear_status (clear_status)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [SW-1:0] randSet();
        logic [SW-1:0] v;
        for (int k = 0; k < NCH; k++)
            v[k*PRECISION +: PRECISION] = PRECISION'($urandom_range(0, 1023));
        return v;
    endfunction

    task automatic applyStimulus(input logic [SW-1:0] codes);
        adc_valid = 1'b1;
        adc_code  = codes;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic expectSet(input logic [SW-1:0] codes);
        for (int ch = 0; ch < NCH; ch++)
            expQ.push_back(16'(ch*4096 + int'(codes[ch*PRECISION +: PRECISION])));
    endtask

    task automatic drainCheck(input string tag);
        int n;
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, ":valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, ":word"}, 32'(out_data), 32'(expQ.pop_front()));
            out_rd = 1'b1;
            tick();
            out_rd = 1'b0;
        end
        checkOutput({tag, ":empty"}, 32'(fifo_count), 32'd0);
    endtask

    task automatic waitState(input logic [1:0] target, input string tag);
        int i;
        i = 0;
        while (state_o != target && i < 40) begin
            tick();
            i++;
        end
        checkOutput(tag, 32'(state_o), 32'(target));
    endtask

    task automatic armWith(input logic [1:0] m);
        mode = m;
        arm  = 1'b1;
        tick();
        arm  = 1'b0;
    endtask

    task automatic doAbort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic doClear();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [SW-1:0] s;
        logic [SW-1:0] s2;
        int trigCodes[4];
        int codes[6];
        int lvl;
        int tc;
        int sc;
        int j;
        logic [1:0] expState;

        rst = 1'b1;
        adc_valid = 1'b0; adc_code = '0; mode = 2'd0; arm = 1'b0; abort = 1'b0;
        trig_ch = 4'd0; trig_level = '0; sample_count = '0; out_rd = 1'b0;
        clear_status = 1'b0;
        idle(3);
        checkOutput("rst_state", 32'(state_o), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'd0);
        checkOutput("rst_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_flags", 32'({overflow, underflow, done}), 32'd0);

        // Arm held across release: the first edge is still in reset, the second accepts it.
        rst  = 1'b0;
        mode = 2'd2;
        arm  = 1'b1;
        tick();
        checkOutput("rstsync_edge1", 32'(state_o), 32'd0);
        tick();
        arm = 1'b0;
        checkOutput("rstsync_edge2", 32'(state_o), 32'd2);
        doAbort();
        checkOutput("abort_idle", 32'(state_o), 32'd0);

        // Immediate single-shot, three spaced sets.
        sample_count = 16'd3;
        armWith(2'd2);
        checkOutput("imm_capture", 32'(state_o), 32'd2);
        for (int i = 0; i < 3; i++) begin
            s = randSet();
            applyStimulus(s);
            expectSet(s);
            idle(6);
        end
        waitState(2'd3, "imm_done_state");
        checkOutput("imm_done_flag", 32'(done), 32'd1);
        checkOutput("imm_count", 32'(fifo_count), 32'd12);
        checkOutput("imm_no_ovf", 32'(overflow), 32'd0);
        applyStimulus(randSet());
        idle(6);
        checkOutput("done_ignores_set", 32'(fifo_count), 32'd12);
        drainCheck("imm");
        doClear();
        checkOutput("done_cleared", 32'(done), 32'd0);

        // Triggered single-shot on channel 1 crossing 512.
        trig_ch = 4'd1;
        trig_level = 10'd512;
        sample_count = 16'd2;
        trigCodes = '{100, 511, 512, 600};
        armWith(2'd1);
        checkOutput("trig_armed", 32'(state_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            s = randSet();
            s[PRECISION +: PRECISION] = PRECISION'(trigCodes[i]);
            applyStimulus(s);
            if (i >= 2) expectSet(s);
            if (i < 2)  checkOutput("trig_not_yet", 32'(state_o), 32'd1);
            if (i == 2) checkOutput("trig_fired", 32'(state_o), 32'd2);
            idle(6);
        end
        waitState(2'd3, "trig_done_state");
        drainCheck("trig");

        // Random trigger trials against the crossing rule.
        for (int t = 0; t < 4; t++) begin
            doClear();
            tc  = $urandom_range(0, NCH-1);
            lvl = $urandom_range(100, 900);
            sc  = $urandom_range(1, 3);
            trig_ch = 4'(tc);
            trig_level = PRECISION'(lvl);
            sample_count = CNT_W'(sc);
            armWith(2'd1);
            j = -1;
            for (int i = 0; i < 6; i++) codes[i] = lvl - 100 + $urandom_range(0, 200);
            for (int i = 1; i < 6; i++)
                if (j < 0 && codes[i-1] < lvl && codes[i] >= lvl) j = i;
            for (int i = 0; i < 6; i++) begin
                s = randSet();
                s[tc*PRECISION +: PRECISION] = PRECISION'(codes[i]);
                applyStimulus(s);
                if (j >= 0 && i >= j && i < j + sc) expectSet(s);
                idle(6);
            end
            idle(4);
            if (j < 0)            expState = 2'd1;
            else if (j + sc <= 6) expState = 2'd3;
            else                  expState = 2'd2;
            checkOutput("rnd_state", 32'(state_o), 32'(expState));
            checkOutput("rnd_done", 32'(done), 32'(expState == 2'd3));
            drainCheck("rnd");
            doAbort();
        end

        // Back-to-back sets: second one dropped.
        doClear();
        armWith(2'd0);
        s  = randSet();
        s2 = randSet();
        adc_valid = 1'b1;
        adc_code  = s;
        tick();
        adc_code  = s2;
        tick();
        adc_valid = 1'b0;
        expectSet(s);
        idle(6);
        checkOutput("b2b_overflow", 32'(overflow), 32'd1);
        checkOutput("b2b_count", 32'(fifo_count), 32'd4);
        checkOutput("b2b_state", 32'(state_o), 32'd2);
        drainCheck("b2b");
        doAbort();
        doClear();
        checkOutput("b2b_cleared", 32'(overflow), 32'd0);

        // Reserved mode runs continuously; fill the FIFO to its limit.
        armWith(2'd3);
        checkOutput("rsvd_capture", 32'(state_o), 32'd2);
        for (int i = 0; i < 4; i++) begin
            s = randSet();
            applyStimulus(s);
            expectSet(s);
            idle(6);
        end
        checkOutput("full_count", 32'(fifo_count), 32'd16);
        checkOutput("full_no_ovf", 32'(overflow), 32'd0);
        applyStimulus(randSet());
        idle(6);
        checkOutput("full_sat_count", 32'(fifo_count), 32'd16);
        checkOutput("full_ovf", 32'(overflow), 32'd1);
        doClear();
        checkOutput("full_ovf_clr", 32'(overflow), 32'd0);
        s = randSet();
        applyStimulus(s);
        for (int k = 0; k < NCH; k++) begin
            checkOutput("full_pop_word", 32'(out_data), 32'(expQ.pop_front()));
            out_rd = 1'b1;
            tick();
        end
        out_rd = 1'b0;
        expectSet(s);
        checkOutput("full_rw_count", 32'(fifo_count), 32'd16);
        checkOutput("full_rw_no_ovf", 32'(overflow), 32'd0);
        drainCheck("full");
        doAbort();

        // Read from an empty FIFO.
        out_rd = 1'b1;
        tick();
        out_rd = 1'b0;
        checkOutput("udf_flag", 32'(underflow), 32'd1);
        checkOutput("udf_data", 32'(out_data), 32'd0);
        checkOutput("udf_valid", 32'(out_valid), 32'd0);
        checkOutput("udf_count", 32'(fifo_count), 32'd0);
        checkOutput("udf_state", 32'(state_o), 32'd0);
        clear_status = 1'b1;
        out_rd = 1'b1;
        tick();
        clear_status = 1'b0;
        out_rd = 1'b0;
        checkOutput("udf_set_wins", 32'(underflow), 32'd1);
        doClear();
        checkOutput("flags_cleared", 32'({overflow, underflow, done}), 32'd0);

        // Abort mid-serialisation keeps flags; reset mid-capture clears them.
        out_rd = 1'b1;
        tick();
        out_rd = 1'b0;
        armWith(2'd0);
        applyStimulus(randSet());
        idle(2);
        doAbort();
        checkOutput("abort_state", 32'(state_o), 32'd0);
        checkOutput("abort_count", 32'(fifo_count), 32'd0);
        checkOutput("abort_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_keeps_flag", 32'(underflow), 32'd1);
        armWith(2'd0);
        applyStimulus(randSet());
        idle(1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_state", 32'(state_o), 32'd0);
        checkOutput("arst_count", 32'(fifo_count), 32'd0);
        checkOutput("arst_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_flags", 32'({overflow, underflow, done}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        checkOutput("post_rst_state", 32'(state_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
